// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder: FSM state
//               encoding, default operand width and a ready-state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Default operand/sum width used by serial_adder
  localparam int SERIAL_ADD_W = 8;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A new request can be accepted in IDLE and, for back-to-back use, in DONE
  function automatic logic is_ready(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
// Module      : fulladder
// Description : Single-bit combinational full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//               accepted start strobe, one bit is resolved per clock through a
//               single fulladder with a registered carry, and the parallel sum
//               and carry-out are registered with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // FSM state and registered status outputs
  state_t state_q, state_d;
  logic   busy_q,  busy_d;
  logic   done_q,  done_d;

  // Datapath registers. part_q holds the upper WIDTH-1 bits of the partial
  // sum; the bit shifted out at the bottom is never needed, so it is not kept.
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-2:0] part_q,  part_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] part_next;

  // One-bit adder cell working on the current LSBs and the stored carry
  fulladder u_fulladder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign accept    = start && is_ready(state_q);
  assign last_bit  = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign part_next = {fa_s, part_q};

  // State register plus registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags follow the state being entered so they are flop outputs
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
      part_d  = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_c;
      cnt_d   = cnt_q + CNT_W'(1);
      part_d  = part_next[WIDTH-1:1];
      // Result registers only move on the final bit
      if (last_bit) begin
        sum_d  = part_next;
        cout_d = fa_c;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8). A transaction
//               level model tracks cycles since acceptance and the expected
//               {cout,sum}; a compare process checks the outputs each cycle,
//               and directed vectors pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: t = edges since acceptance (-1 = nothing in flight),
  // result register updates when t reaches W.
  int       t     = -1;
  logic [W:0] m_pend = '0;
  logic [W:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     = -1;
      m_res = '0;
    end else begin
      if ((t < 0 || t == W) && start) begin
        t      = 0;
        m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      end else if (t >= 0 && t < W) begin
        t++;
        if (t == W) m_res = m_pend;
      end else begin
        t = -1;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    check("done", {31'd0, done}, {31'd0, (t == W)});
    if (t >= 1)
      check("busy", {31'd0, busy}, {31'd0, (t < W)});
    else if (t < 0)
      check("busy_idle", {31'd0, busy}, 32'd0);
    check("result", {23'd0, cout, sum}, {23'd0, m_res});
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
  end

  // Issue one add from a ready state; checks latency and the result
  task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W:0] exp, input string tag);
    int   lat;
    logic got;
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    lat   = 0;
    got   = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_sum"}, {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    int done_cnt;
    int prev;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results
    do_add(8'h00, 8'h00, 1'b0, 9'h000, "zero");
    do_add(8'h3C, 8'h42, 1'b0, 9'h07E, "3c_42");
    do_add(8'hFF, 8'h01, 1'b0, 9'h100, "ff_01");
    do_add(8'hA5, 8'h5A, 1'b1, 9'h100, "a5_5a_c1");

    // Start held high with operands changing every cycle
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    start = 1'b1;
    done_cnt = 0;
    prev     = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      if (done) begin
        done_cnt++;
        if (prev < 0) check("b2b_first", cyc, W + 1);
        else          check("b2b_period", cyc - prev, W + 1);
        prev = cyc;
      end
    end
    start = 1'b0;
    check("b2b_count", done_cnt, 4);
    repeat (12) @(negedge clk);

    // Reset three cycles into RUN
    a     = 8'h77;
    b     = 8'h11;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum",  {24'd0, sum},  32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_add(8'h01, 8'h01, 1'b0, 9'h002, "post_rst");

    // Random soak, sometimes with idle gaps, sometimes back-to-back
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_add(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (W+1)'(rc), "soak");
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that resolves one bit per clock through a single `fulladder` cell plus a registered carry. It sits directly downstream of the team's combinational `fulladder`. It takes two parallel operands and a carry-in on a start strobe, and returns a registered parallel sum and carry-out with a one-cycle done pulse. It trades latency for area wherever a wide ripple adder is not justified.

## Interface
- `WIDTH`, default 8: operand/sum width in bits, minimum 2.
- `clk`  input  1: single clock; all state is updated on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request; sampled only when the block is ready (IDLE or DONE).
- `a`  input  WIDTH: operand A; captured on accepted start.
- `b`  input  WIDTH: operand B; captured on accepted start.
- `cin`  input  1: carry-in; captured on accepted start.
- `busy`  output  1: high while in RUN.
- `done`  output  1: one-cycle pulse; `sum`/`cout` are valid from this cycle.
- `sum`  output  WIDTH: result register; holds until the next completion.
- `cout`  output  1: final carry; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → load shift regs A←`a`, B←`b`, carry←`cin`, bit counter←0; go to RUN.
  - `start`=0 → stay in IDLE.
- RUN, every cycle:
  - `fulladder`(A[0], B[0], carry) produces s and c.
  - carry←c; A and B shift right by 1 with zero fill.
  - Partial-sum shift register shifts right with s entering at MSB.
  - counter←counter+1.
- RUN exit: on the cycle where counter == WIDTH-1, the shift completes. Then:
  - `sum`←completed partial sum, which is {s, partial[WIDTH-1:1]}.
  - `cout`←c.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE, allowing back-to-back operations with no bubble.
  - Otherwise go to IDLE.
- `start` during RUN is ignored; the in-flight operation is unaffected and the request is not queued.
- `a`, `b` and `cin` may change freely after acceptance.
- Arithmetic: {`cout`,`sum`} == `a` + `b` + `cin`, computed modulo 2^(WIDTH+1), so there is no overflow loss.
- Counter width: $clog2(WIDTH); it never wraps during a valid operation.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0; state=IDLE; all internal registers 0.
- Latency: `start` accepted at edge k → `busy`=1 after edges k+1..k+WIDTH-1 → `done`=1 after edge k+WIDTH, for one cycle.
- Throughput: one add every WIDTH+1 cycles from IDLE; every WIDTH+1 cycles when back-to-back (start in DONE).
- `sum`/`cout` change only on the RUN→DONE edge. They stay stable through IDLE and the following RUN.
- Reset asserted mid-RUN: everything clears immediately and asynchronously, with no `done` pulse. The first `start` after deassertion is accepted normally.
- `busy` and `done` are never high together.

## Structure
- Sub-module: instance of the existing `fulladder` (ports a, b, cin, sum, carry), used unchanged.
- Shared package: state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a default-width constant, SERIAL_ADD_W=8.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

## Test plan
- With WIDTH=8, reset, then each of the following:
  - `a`=8'h00, `b`=8'h00, `cin`=0 → `done` 8 cycles after start; `sum`=8'h00, `cout`=0. Separately, `a`=8'h3C, `b`=8'h42, `cin`=0 → `sum`=8'h7E, `cout`=0.
  - `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `cout`=1. Also `a`=8'hA5, `b`=8'h5A, `cin`=1 → `sum`=8'h00, `cout`=1.
  - Hold `start`=1 continuously with changing operands → results complete every 9 cycles. Each result matches the operands captured at its own acceptance; mid-RUN starts are ignored.
  - Assert `rst_n`=0 three cycles into RUN → outputs are 0 immediately and no `done` pulse appears. A fresh add of `a`=8'h01, `b`=8'h01 then gives `sum`=8'h02.
  - Random soak of 1000 operations with a reference model of `a`+`b`+`cin` → all match, and `busy`/`done` are never high together.
